dac_window_sequencer: RTL
=========================

DAC_WINDOW_SEQUENCER -- requirements
Module: dac_window_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the window counter, refractory counter, config inputs and event counters.
REQ-002 Parameter PULSE_LEN, default 4: trigger pulse width in state_clk cycles, legal range 1..255.
REQ-003 Clocking and reset: reset reset, synchronous, active-high; clock state_clk.
REQ-004 state_clk  input  1  one rising edge per DAC sample frame; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 enable  input  1  sequencer run; low forces IDLE.
REQ-007 thrsh_a  input  1  arming comparator, from DAC channel A threshold output.
REQ-008 thrsh_b  input  1  qualifying comparator, from DAC channel B threshold output.
REQ-009 win_start  input  CNT_W  window open count, inclusive.
REQ-010 win_stop  input  CNT_W  window close count, exclusive.
REQ-011 refractory  input  CNT_W  refractory length in cycles.
REQ-012 state_counter  output  CNT_W  frames since arming; drives the DAC datapath state-counter input.
REQ-013 inwin  output  1  combinational: (state_counter >= win_start) and (state_counter < win_stop).
REQ-014 trig_out  output  1  trigger pulse.
REQ-015 state  output  3  encoded FSM state: IDLE=0, ARMED=1, COUNT=2, TRIG=3, REFRACT=4.
REQ-016 hit_count  output  CNT_W  number of TRIG entries, wrapping.
REQ-017 miss_count  output  CNT_W  number of window timeouts, wrapping.

Function
REQ-018 A register thrsh_a_d SHALL sample thrsh_a every cycle in every state; the arm event is thrsh_a and not thrsh_a_d.
REQ-019 IDLE: if enable is high, the next state SHALL be ARMED and state_counter SHALL be 0.
REQ-020 ARMED: on an arm event, the next state SHALL be COUNT with state_counter set to 0; otherwise the FSM stays in ARMED.
REQ-021 COUNT hit: if inwin and thrsh_b are both high, the next state SHALL be TRIG, state_counter SHALL hold its value, and hit_count SHALL increment by 1.
REQ-022 COUNT miss: if there is no hit and state_counter >= win_stop, the next state SHALL be ARMED, state_counter SHALL be 0, and miss_count SHALL increment by 1.
REQ-023 COUNT otherwise: state_counter SHALL increment by 1 per cycle, saturating at all-ones.
REQ-024 Hit SHALL take priority over miss; both cannot occur together because inwin requires state_counter < win_stop.
REQ-025 TRIG: trig_out SHALL be high exactly during cycles in TRIG; the FSM SHALL stay in TRIG for PULSE_LEN cycles, then go to REFRACT with state_counter at 0 and the refractory counter at 0.
REQ-026 REFRACT: the refractory counter SHALL increment each cycle; when it is >= refractory, the next state SHALL be ARMED; refractory=0 gives exactly one REFRACT cycle.
REQ-027 Arm events outside ARMED SHALL be ignored, with no retrigger in COUNT, TRIG or REFRACT.
REQ-028 If thrsh_a is held high on entry to ARMED, it SHALL NOT arm the FSM; a new rising edge is required.
REQ-029 enable low in any non-IDLE state SHALL force IDLE next cycle, clear state_counter, the refractory counter and the pulse counter, and drop trig_out; event counters SHALL be retained.
REQ-030 Config inputs SHALL be used live, with no latching; a change mid-COUNT takes effect on the next cycle.
REQ-031 If win_start >= win_stop, the window is empty and every armed sequence SHALL end in a miss.
REQ-032 If win_stop = 0, a miss SHALL occur on the first COUNT cycle.
REQ-033 Saturated state_counter with win_stop = all-ones SHALL produce a miss.

Reset
REQ-034 On reset: state=IDLE, state_counter=0, trig_out=0, hit_count=0, miss_count=0, thrsh_a_d=0, refractory and pulse counters at 0.
REQ-035 Reset SHALL have priority over enable and all events, and SHALL take effect from any state, including mid-TRIG (trig_out low the next cycle).

Verification
REQ-036 Hit: win_start=3, win_stop=6, PULSE_LEN=4, thrsh_b=1, arm at cycle N -> COUNT at N+1 (counter=0), TRIG at N+5 with counter=3, trig_out high N+5..N+8, hit_count=1.
REQ-037 Miss: win_start=3, win_stop=6, thrsh_b=0, arm at N -> counter reaches 6 at N+7, state=ARMED at N+8, miss_count=1, trig_out never high.
REQ-038 Refractory: refractory=10, arm events each cycle after TRIG -> ignored; ARMED 11 cycles after REFRACT entry; thrsh_a held high prevents re-arm until it toggles low then high.
REQ-039 Edge cases: win_start=5, win_stop=5 -> miss at counter=5; win_stop=0 -> miss on the first COUNT cycle.
REQ-040 Abort: enable dropped mid-COUNT (counter=2) -> IDLE next cycle, counter=0, counts retained; reset asserted mid-TRIG -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/dac_window_sequencer.sv
// Arm / window / trigger sequencer driven once per DAC sample frame.
// Arms on a rising edge of thrsh_a, fires a fixed-width pulse when thrsh_b lands inside the count window.
module dac_window_sequencer #(
  parameter int CNT_W     = 16,
  parameter int PULSE_LEN = 4
) (
  input  logic             state_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             thrsh_a,
  input  logic             thrsh_b,
  input  logic [CNT_W-1:0] win_start,
  input  logic [CNT_W-1:0] win_stop,
  input  logic [CNT_W-1:0] refractory,
  output logic [CNT_W-1:0] state_counter,
  output logic             inwin,
  output logic             trig_out,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_COUNT   = 3'd2,
    ST_TRIG    = 3'd3,
    ST_REFRACT = 3'd4
  } state_t;

  localparam logic [7:0]       PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_refr;
  logic [CNT_W-1:0] r_hit;
  logic [CNT_W-1:0] r_miss;
  logic [7:0]       r_pulse;
  logic             r_trig;
  logic             r_thrsh_a_d;

  logic w_arm;
  logic w_inwin;
  logic w_hit;
  logic w_miss;

  assign w_arm   = thrsh_a & ~r_thrsh_a_d;
  assign w_inwin = (r_cnt >= win_start) && (r_cnt < win_stop);
  assign w_hit   = w_inwin & thrsh_b;
  assign w_miss  = (r_cnt >= win_stop);

  always_ff @(posedge state_clk) begin
    r_thrsh_a_d <= reset ? 1'b0 : thrsh_a;
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_refr  <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
      r_pulse <= '0;
      r_trig  <= 1'b0;
    end else if (!enable) begin
      // Abort path: event counters survive so software can still read them.
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_refr  <= '0;
      r_pulse <= '0;
      r_trig  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ARMED;
          r_cnt   <= '0;
        end
        ST_ARMED: begin
          if (w_arm) begin
            r_state <= ST_COUNT;
            r_cnt   <= '0;
          end
        end
        ST_COUNT: begin
          // A hit implies cnt < win_stop, so it can never collide with a miss.
          if (w_hit) begin
            r_state <= ST_TRIG;
            r_trig  <= 1'b1;
            r_pulse <= '0;
            r_hit   <= r_hit + CNT_ONE;
          end else if (w_miss) begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
            r_miss  <= r_miss + CNT_ONE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_TRIG: begin
          if (r_pulse == PULSE_LAST) begin
            r_state <= ST_REFRACT;
            r_trig  <= 1'b0;
            r_cnt   <= '0;
            r_refr  <= '0;
          end else begin
            r_pulse <= r_pulse + 8'd1;
          end
        end
        ST_REFRACT: begin
          if (r_refr >= refractory) r_state <= ST_ARMED;
          r_refr <= r_refr + CNT_ONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_trig  <= 1'b0;
        end
      endcase
    end
  end

  assign state_counter = r_cnt;
  assign inwin         = w_inwin;
  assign trig_out      = r_trig;
  assign state         = r_state;
  assign hit_count     = r_hit;
  assign miss_count    = r_miss;

endmodule
